// File: rtl/pipelined_barrel_shifter.sv
// Barrel shifter that resolves one shift-amount bit per pipeline stage ($clog2(N) stages).
// Latency is SW edges including the accept edge, with one request per cycle and no backpressure.
module pipelined_barrel_shifter #(
   parameter  int N  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_vld,
   input  logic [N-1:0]  up_data,
   input  logic [SW-1:0] up_shamt,
   input  logic          up_dir,
   input  logic [1:0]    up_mode,
   output logic          down_vld,
   output logic [N-1:0]  down_data
);

   localparam logic [1:0] MODE_ARITH = 2'b01;
   localparam logic [1:0] MODE_ROT   = 2'b10;

   logic [SW-1:0] vld_q;
   logic [N-1:0]  data_q  [SW];
   logic [SW-1:0] shamt_q [SW];
   logic          dir_q   [SW];
   logic [1:0]    mode_q  [SW];

   logic          in_vld   [SW];
   logic [N-1:0]  in_data  [SW];
   logic [SW-1:0] in_shamt [SW];
   logic          in_dir   [SW];
   logic [1:0]    in_mode  [SW];
   logic [N-1:0]  nxt_data [SW];

   // Arithmetic right keeps the MSB in place, so every later stage still
   // replicates the operand's original sign bit.
   function automatic logic [N-1:0] stage_shift(input logic [N-1:0] d, input int sh,
                                                input logic dir, input logic [1:0] mode);
      logic [N-1:0] r;
      if (mode == MODE_ROT)
         r = dir ? ((d >> sh) | (d << (N - sh))) : ((d << sh) | (d >> (N - sh)));
      else if (dir && mode == MODE_ARITH)
         r = N'($signed(d) >>> sh);
      else if (dir)
         r = d >> sh;
      else
         r = d << sh;
      return r;
   endfunction

   always_comb begin
      in_vld[0]   = up_vld;
      in_data[0]  = up_data;
      in_shamt[0] = up_shamt;
      in_dir[0]   = up_dir;
      in_mode[0]  = up_mode;
      for (int k = 1; k < SW; k++) begin
         in_vld[k]   = vld_q[k-1];
         in_data[k]  = data_q[k-1];
         in_shamt[k] = shamt_q[k-1];
         in_dir[k]   = dir_q[k-1];
         in_mode[k]  = mode_q[k-1];
      end
      for (int k = 0; k < SW; k++) begin
         nxt_data[k] = in_shamt[k][k] ? stage_shift(in_data[k], 1 << k, in_dir[k], in_mode[k])
                                      : in_data[k];
      end
   end

   // Payload registers only load behind a valid so the output holds across bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 0; k < SW; k++) begin
            data_q[k]  <= '0;
            shamt_q[k] <= '0;
            dir_q[k]   <= 1'b0;
            mode_q[k]  <= 2'b00;
         end
      end else begin
         for (int k = 0; k < SW; k++) begin
            vld_q[k] <= in_vld[k];
            if (in_vld[k]) begin
               data_q[k]  <= nxt_data[k];
               shamt_q[k] <= in_shamt[k];
               dir_q[k]   <= in_dir[k];
               mode_q[k]  <= in_mode[k];
            end
         end
      end
   end

   assign down_vld  = vld_q[SW-1];
   assign down_data = data_q[SW-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomized checks of the pipelined barrel shifter at N = 8.
module tb_pipelined_barrel_shifter;

   localparam int N  = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          up_vld;
   logic [N-1:0]  up_data;
   logic [SW-1:0] up_shamt;
   logic          up_dir;
   logic [1:0]    up_mode;
   logic          down_vld;
   logic [N-1:0]  down_data;

   int checks = 0;
   int errors = 0;

   pipelined_barrel_shifter #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .up_vld(up_vld), .up_data(up_data), .up_shamt(up_shamt),
      .up_dir(up_dir), .up_mode(up_mode),
      .down_vld(down_vld), .down_data(down_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [2:0] shamt;
      logic       dir;
      logic [1:0] mode;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      logic [7:0] exp;
      int         acc;
   } sb_t;

   vec_t vecs [14];
   sb_t  sb [$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Bitwise reference, independent of the staged decomposition.
   function automatic logic [7:0] ref_shift(input logic [7:0] d, input int sh,
                                            input logic dir, input logic [1:0] mode);
      logic [7:0] r;
      for (int i = 0; i < N; i++) begin
         if (mode == 2'b10)
            r[i] = dir ? d[(i + sh) % N] : d[(i - sh + N) % N];
         else if (dir)
            r[i] = (i + sh < N) ? d[i + sh] : ((mode == 2'b01) ? d[N-1] : 1'b0);
         else
            r[i] = (i >= sh) ? d[i - sh] : 1'b0;
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s,
                        input logic dir, input logic [1:0] m);
      up_vld   = v;
      up_data  = d;
      up_shamt = s;
      up_dir   = dir;
      up_mode  = m;
   endtask

   logic       obs_vld  [10];
   logic [7:0] obs_data [10];
   vec_t       strm [6];
   logic [7:0] strm_exp [6];
   logic       strm_vld [6];

   initial begin
      vecs[0]  = '{8'hB3, 3'd3, 1'b0, 2'b00, 8'h98};
      vecs[1]  = '{8'hB3, 3'd3, 1'b1, 2'b00, 8'h16};
      vecs[2]  = '{8'hB3, 3'd3, 1'b1, 2'b01, 8'hF6};
      vecs[3]  = '{8'hB3, 3'd3, 1'b0, 2'b10, 8'h9D};
      vecs[4]  = '{8'hB3, 3'd3, 1'b1, 2'b10, 8'h76};
      vecs[5]  = '{8'h5A, 3'd0, 1'b0, 2'b00, 8'h5A};
      vecs[6]  = '{8'h5A, 3'd0, 1'b1, 2'b01, 8'h5A};
      vecs[7]  = '{8'h5A, 3'd0, 1'b0, 2'b10, 8'h5A};
      vecs[8]  = '{8'h5A, 3'd0, 1'b1, 2'b11, 8'h5A};
      vecs[9]  = '{8'h81, 3'd1, 1'b0, 2'b01, 8'h02};
      vecs[10] = '{8'hB3, 3'd3, 1'b1, 2'b11, 8'h16};
      vecs[11] = '{8'h80, 3'd7, 1'b1, 2'b01, 8'hFF};
      vecs[12] = '{8'h01, 3'd7, 1'b1, 2'b10, 8'h02};
      vecs[13] = '{8'hC1, 3'd7, 1'b0, 2'b10, 8'hE0};

      strm[0] = '{8'hA5, 3'd1, 1'b0, 2'b10, 8'h4B};
      strm[1] = '{8'hA5, 3'd4, 1'b1, 2'b00, 8'h0A};
      strm[2] = '{8'h80, 3'd7, 1'b1, 2'b01, 8'hFF};
      strm[3] = '{8'h01, 3'd7, 1'b0, 2'b00, 8'h80};
      strm[4] = '{8'h00, 3'd0, 1'b0, 2'b00, 8'h00};
      strm[5] = '{8'h01, 3'd1, 1'b1, 2'b10, 8'h80};
      strm_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      strm_exp = '{8'h4B, 8'h0A, 8'hFF, 8'h80, 8'h80, 8'h80};

      // Reset then idle
      drive(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
      rst = 1'b1;
      #1;
      check("rst_vld", {31'd0, down_vld}, 32'd0);
      check("rst_data", {24'd0, down_data}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("idle_vld_%0d", c), {31'd0, down_vld}, 32'd0);
         check($sformatf("idle_data_%0d", c), {24'd0, down_data}, 32'd0);
      end

      // Single requests: latency and value
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].data, vecs[i].shamt, vecs[i].dir, vecs[i].mode);
         @(posedge clk);
         #1 drive(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
         check($sformatf("vec%0d_lat1", i), {31'd0, down_vld}, 32'd0);
         @(posedge clk);
         #1 check($sformatf("vec%0d_lat2", i), {31'd0, down_vld}, 32'd0);
         @(posedge clk);
         #1 check($sformatf("vec%0d_vld", i), {31'd0, down_vld}, 32'd1);
         check($sformatf("vec%0d_data", i), {24'd0, down_data}, {24'd0, vecs[i].exp});
         @(posedge clk);
         #1 check($sformatf("vec%0d_drop", i), {31'd0, down_vld}, 32'd0);
      end

      // Back-to-back stream with one bubble; data must hold during the bubble
      for (int c = 0; c < 10; c++) begin
         if (c < 6)
            drive(strm_vld[c], strm[c].data, strm[c].shamt, strm[c].dir, strm[c].mode);
         else
            drive(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
         @(posedge clk);
         #1;
         obs_vld[c]  = down_vld;
         obs_data[c] = down_data;
      end
      check("strm_pre0", {31'd0, obs_vld[0]}, 32'd0);
      check("strm_pre1", {31'd0, obs_vld[1]}, 32'd0);
      for (int c = 0; c < 6; c++) begin
         check($sformatf("strm%0d_vld", c), {31'd0, obs_vld[c+2]}, {31'd0, strm_vld[c]});
         check($sformatf("strm%0d_data", c), {24'd0, obs_data[c+2]}, {24'd0, strm_exp[c]});
      end
      check("strm_tail", {31'd0, obs_vld[8]}, 32'd0);

      // Reset mid-flight
      drive(1'b1, 8'h11, 3'd1, 1'b0, 2'b00);
      @(posedge clk);
      #1 drive(1'b1, 8'h22, 3'd1, 1'b0, 2'b00);
      @(posedge clk);
      #1 drive(1'b1, 8'h33, 3'd1, 1'b0, 2'b00);
      @(posedge clk);
      #1 drive(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
      check("mid_first_vld", {31'd0, down_vld}, 32'd1);
      check("mid_first_data", {24'd0, down_data}, 32'h22);
      #2 rst = 1'b1;
      #1;
      check("mid_async_vld", {31'd0, down_vld}, 32'd0);
      check("mid_async_data", {24'd0, down_data}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1 check($sformatf("mid_quiet_%0d", c), {31'd0, down_vld}, 32'd0);
      end
      drive(1'b1, 8'h0F, 3'd2, 1'b0, 2'b10);
      @(posedge clk);
      #1 drive(1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
      check("post_lat1", {31'd0, down_vld}, 32'd0);
      @(posedge clk);
      #1 check("post_lat2", {31'd0, down_vld}, 32'd0);
      @(posedge clk);
      #1 check("post_vld", {31'd0, down_vld}, 32'd1);
      check("post_data", {24'd0, down_data}, 32'h3C);

      // Random sweep against the reference model
      begin
         int issued = 0;
         int cyc = 0;
         int iter = 0;
         while ((issued < 200 || sb.size() != 0) && iter < 2000) begin
            iter++;
            if (issued < 200 && $urandom_range(0, 3) != 0) begin
               logic [7:0] d;
               logic [2:0] s;
               logic       dr;
               logic [1:0] m;
               sb_t        e;
               d  = 8'($urandom);
               s  = 3'($urandom_range(0, 7));
               dr = 1'($urandom_range(0, 1));
               m  = 2'($urandom_range(0, 3));
               drive(1'b1, d, s, dr, m);
               e.exp = ref_shift(d, int'(s), dr, m);
               e.acc = cyc + 1;
               sb.push_back(e);
               issued++;
            end else begin
               drive(1'b0, 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 2'b00);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (down_vld) begin
               if (sb.size() == 0) begin
                  check("rnd_unexpected", 32'd1, 32'd0);
               end else begin
                  sb_t e;
                  e = sb.pop_front();
                  check($sformatf("rnd_data_c%0d", cyc), {24'd0, down_data}, {24'd0, e.exp});
                  check($sformatf("rnd_lat_c%0d", cyc), cyc, e.acc + SW - 1);
               end
            end
         end
         check("rnd_drained", sb.size(), 32'd0);
         check("rnd_issued", issued, 32'd200);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Registered, multi-cycle counterpart of the team's single-cycle combinational shift blocks. Accepts one shift request per clock and resolves the shift amount one bit per pipeline stage, log2(N) stages in total. Supports logical and arithmetic shifts and rotation in both directions. Sits downstream of operand producers and feeds the result consumer through a valid-qualified stream.

Parameters:
N, 8, data width in bits; must be a power of two and at least 2
SW, $clog2(N), shift-amount width and number of pipeline stages; derived, not to be overridden

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
up_vld  input  1  request valid
up_data  input  N  operand
up_shamt  input  SW  shift amount, 0..N-1
up_dir  input  1  0 = left, 1 = right
up_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
down_vld  output  1  result valid
down_data  output  N  shifted result

Behaviour:
- Reset and clocking:
  - One clock. Reset is asynchronous and active-high.
  - While rst is high, all stage valid bits clear to 0 immediately, without waiting for a clock edge.
  - While rst is high, all stage data, shamt, dir and mode registers clear to 0.
  - down_vld = 0 and down_data = 0 while in reset.
- Pipeline:
  - SW register stages, indexed k = 0..SW-1.
  - Stage k takes the previous stage's data (up_data for k = 0).
  - If the carried shamt bit k is 1, stage k shifts by 2^k in the carried direction and mode; if it is 0, the data passes through unchanged.
  - Each stage carries valid, data, shamt, dir and mode forward.
- Latency and throughput:
  - A request accepted on edge T appears on down_vld/down_data after edge T+SW-1. For N = 8 this is 3 edges, counting the accept edge.
  - Throughput is one request per cycle; there is no backpressure.
  - Bubbles (up_vld = 0) propagate in place. Output order equals input order.
- Data hold rule: a stage's data, shamt, dir and mode registers load only when its input valid is 1, otherwise they hold. down_data therefore holds the last result while down_vld = 0.
- Left shifts: zero-fill from the LSB for both logical and arithmetic mode.
- Right shifts:
  - Logical: zero-fill from the MSB.
  - Arithmetic: fill with the operand's original MSB (replicated sign).
- Rotate: bits shifted out re-enter at the opposite end; no bits are lost.
- Boundary cases:
  - shamt = 0 gives down_data equal to up_data in every mode.
  - shamt = N-1 is the maximum; no out-of-range shift exists.
- Reset mid-operation: in-flight requests are discarded. The first down_vld after rst is released comes from a request accepted after release, no earlier than SW edges later.
- up_data, up_shamt, up_dir and up_mode are don't-care when up_vld = 0.

Test Plan:
- Reset then idle: hold rst for 2 cycles, release, keep up_vld = 0 for 10 cycles -> down_vld stays 0 and down_data stays 0 throughout.
- N = 8, up_data = 10110011, shamt = 3, single request per case:
  - logical left -> down_data = 10011000
  - logical right -> 00010110
  - arithmetic right -> 11110110
  - rotate left -> 10011101
  - rotate right -> 01110110
  - each result with down_vld = 1 exactly 3 cycles after acceptance
- Pass-through: up_data = 01011010 with shamt = 0 in every mode -> down_data = 01011010. Arithmetic left on 10000001 with shamt = 1 -> 00000010.
- Back-to-back stream: 4 consecutive valid requests (A5 rot-left 1, A5 log-right 4, 80 arith-right 7, 01 log-left 7), then 1 bubble, then 01 rot-right 1 -> in order: 4B, 0A, FF, 80, one bubble cycle with down_vld = 0, then 80.
- Reset mid-flight: issue 3 valid requests and assert rst asynchronously between edges after the second -> down_vld drops to 0 immediately, with no output from the discarded requests after release. A new request issued after release appears 3 cycles later.
- Random sweep: 200 random data/shamt/dir/mode requests with random bubbles -> every result equals the combinational reference model of the same operation, delayed by SW cycles.
